// File: rtl/mcu_spi_pkg.sv
// Shared definitions for the MCU SPI control link: target ids, OSD commands
// and the frame decoder state encoding.
package mcu_spi_pkg;

  localparam logic [7:0] TGT_HID        = 8'h01;
  localparam logic [7:0] TGT_CFG        = 8'h02;
  localparam logic [7:0] TGT_OSD        = 8'h03;

  localparam logic [7:0] OSD_CMD_ENABLE = 8'h01;
  localparam logic [7:0] OSD_CMD_WRITE  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TARGET,
    ST_COMMAND,
    ST_DATA,
    ST_WAIT_CS
  } state_t;

endpackage

// File: rtl/mcu_spi_target_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with optional edge detection
// against one extra flop behind the synchronised level.
module sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0,
  parameter bit EDGE      = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_level = r_chain[STAGES-1];

  generate
    if (EDGE) begin : g_edge
      logic r_prev;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_prev <= RESET_VAL;
        end else begin
          r_prev <= r_chain[STAGES-1];
        end
      end

      assign o_rise = r_chain[STAGES-1] & ~r_prev;
      assign o_fall = ~r_chain[STAGES-1] & r_prev;
    end else begin : g_no_edge
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: oversamples the MCU link in the system clock domain and
// turns each frame into a target id plus a byte-strobed command stream.
module mcu_spi_target
  import mcu_spi_pkg::*;
#(
  parameter logic [7:0] OSD_TARGET  = TGT_OSD,
  parameter logic [7:0] ID_BYTE     = 8'h5C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_spi_sclk,
  input  logic       i_spi_csn,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  input  logic [7:0] i_resp_data,
  output logic [7:0] o_tgt,
  output logic       o_data_strobe,
  output logic       o_data_start,
  output logic [7:0] o_data,
  output logic       o_osd_strobe,
  output logic       o_busy
);

  logic w_unusedSclkLevel, w_sclkRise, w_sclkFall;
  logic w_csn, w_csRise, w_csFall;
  logic w_mosi, w_unusedMosiRise, w_unusedMosiFall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE(1'b1)) u_sclk (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_spi_sclk),
    .o_level(w_unusedSclkLevel), .o_rise(w_sclkRise), .o_fall(w_sclkFall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE(1'b1)) u_csn (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_spi_csn),
    .o_level(w_csn), .o_rise(w_csRise), .o_fall(w_csFall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE(1'b0)) u_mosi (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(i_spi_mosi),
    .o_level(w_mosi), .o_rise(w_unusedMosiRise), .o_fall(w_unusedMosiFall)
  );

  state_t                 r_state;
  logic [6:0]             r_rxShift;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_txShift;
  logic                   r_skipFall;
  logic [SYNC_STAGES:0]   r_warm;
  logic [7:0]             r_tgt;
  logic [7:0]             r_data;
  logic                   r_dataStrobe;
  logic                   r_dataStart;
  logic                   r_osdStrobe;
  logic                   r_busy;

  logic       w_active;
  logic       w_byteDone;
  logic [7:0] w_rxByte;

  assign w_active   = (r_state == ST_TARGET) || (r_state == ST_COMMAND) || (r_state == ST_DATA);
  assign w_byteDone = w_active && w_sclkRise && (r_bitCnt == 3'd7);
  assign w_rxByte   = {r_rxShift, w_mosi};

  // r_warm fills with ones once the CSN chain holds real pin samples; a low CSN
  // seen before that means reset was released mid-frame.
  // The fall right after a byte boundary must not shift, or the freshly loaded
  // reply MSB would be lost before the MCU samples it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_rxShift    <= '0;
      r_bitCnt     <= '0;
      r_txShift    <= '0;
      r_skipFall   <= 1'b0;
      r_warm       <= '0;
      r_tgt        <= '0;
      r_data       <= '0;
      r_dataStrobe <= 1'b0;
      r_dataStart  <= 1'b0;
      r_osdStrobe  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_warm       <= {r_warm[SYNC_STAGES-1:0], 1'b1};
      r_busy       <= ~w_csn;
      r_dataStrobe <= 1'b0;
      r_dataStart  <= 1'b0;
      r_osdStrobe  <= 1'b0;

      if (w_active && w_sclkRise) begin
        r_rxShift <= w_rxByte[6:0];
        r_bitCnt  <= r_bitCnt + 3'd1;
      end

      if (w_byteDone) begin
        r_txShift  <= i_resp_data;
        r_skipFall <= 1'b1;
        if (r_state == ST_TARGET) begin
          r_tgt <= w_rxByte;
        end else begin
          r_data       <= w_rxByte;
          r_dataStrobe <= 1'b1;
          r_dataStart  <= (r_state == ST_COMMAND);
          r_osdStrobe  <= (r_tgt == OSD_TARGET);
        end
      end else if (w_active && w_sclkFall) begin
        if (r_skipFall) begin
          r_skipFall <= 1'b0;
        end else begin
          r_txShift <= {r_txShift[6:0], 1'b0};
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (!r_warm[SYNC_STAGES] && !w_csn) begin
            r_state <= ST_WAIT_CS;
          end else if (w_csFall) begin
            r_state    <= ST_TARGET;
            r_txShift  <= ID_BYTE;
            r_rxShift  <= '0;
            r_bitCnt   <= '0;
            r_skipFall <= 1'b0;
          end
        end
        ST_TARGET:  if (w_byteDone) r_state <= ST_COMMAND;
        ST_COMMAND: if (w_byteDone) r_state <= ST_DATA;
        ST_DATA:    r_state <= ST_DATA;
        ST_WAIT_CS: r_state <= ST_WAIT_CS;
        default:    r_state <= ST_IDLE;
      endcase

      if (w_csRise) begin
        r_state    <= ST_IDLE;
        r_bitCnt   <= '0;
        r_txShift  <= '0;
        r_skipFall <= 1'b0;
      end
    end
  end

  assign o_spi_miso    = r_txShift[7];
  assign o_tgt         = r_tgt;
  assign o_data_strobe = r_dataStrobe;
  assign o_data_start  = r_dataStart;
  assign o_data        = r_data;
  assign o_osd_strobe  = r_osdStrobe;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Self-checking bench for mcu_spi_target: plays the MCU side of the link with
// directed and random frames and compares against a frame-level model.
module tb_mcu_spi_target;
  import mcu_spi_pkg::*;

  localparam logic [7:0] ID = 8'h5C;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sclk;
  logic       csn;
  logic       mosi;
  logic [7:0] respData;
  logic       miso;
  logic [7:0] tgt;
  logic       dataStrobe;
  logic       dataStart;
  logic [7:0] data;
  logic       osdStrobe;
  logic       busy;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] txBytes[$];
  logic [7:0] obsData[$];
  logic       obsStart[$];
  logic       obsOsd[$];
  logic       obsStrb[$];
  logic [7:0] obsMiso[$];
  logic [7:0] misoShift;
  logic       lastStrobe = 1'b0;
  logic       busyMid;

  always #10 clk = ~clk;

  mcu_spi_target #(
    .OSD_TARGET(TGT_OSD),
    .ID_BYTE(ID),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_reset_n(resetN),
    .i_spi_sclk(sclk),
    .i_spi_csn(csn),
    .i_spi_mosi(mosi),
    .o_spi_miso(miso),
    .i_resp_data(respData),
    .o_tgt(tgt),
    .o_data_strobe(dataStrobe),
    .o_data_start(dataStart),
    .o_data(data),
    .o_osd_strobe(osdStrobe),
    .o_busy(busy)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Record every strobe pulse and check that no pulse lasts longer than a clock.
  always @(negedge clk) begin
    if (dataStrobe || osdStrobe) begin
      checkOutput("strobeWidth", 32'(lastStrobe), 32'd0);
      obsData.push_back(data);
      obsStart.push_back(dataStart);
      obsOsd.push_back(osdStrobe);
      obsStrb.push_back(dataStrobe);
    end
    lastStrobe = dataStrobe;
  end

  task automatic clearObs();
    obsData.delete();
    obsStart.delete();
    obsOsd.delete();
    obsStrb.delete();
    obsMiso.delete();
  endtask

  // One mode-0 bit: MOSI set while SCLK low, MISO sampled just before the rise.
  task automatic sendBit(input logic b);
    mosi = b;
    #50;
    misoShift = {misoShift[6:0], miso};
    sclk = 1'b1;
    #100;
    sclk = 1'b0;
    #50;
  endtask

  task automatic sendByte(input logic [7:0] value);
    for (int b = 7; b >= 0; b--) sendBit(value[b]);
    obsMiso.push_back(misoShift);
  endtask

  // Sends txBytes as one frame, followed by extraBits random bits of a partial byte.
  task automatic applyStimulus(input int extraBits);
    clearObs();
    csn = 1'b0;
    #200;
    busyMid = busy;
    for (int i = 0; i < txBytes.size(); i++) sendByte(txBytes[i]);
    for (int i = 0; i < extraBits; i++) sendBit(1'($urandom_range(0, 1)));
    #60;
    csn = 1'b1;
    #300;
  endtask

  // Frame-level expectations: byte 0 is the target, the rest become strobes,
  // MISO returns the id byte first and the reply byte afterwards.
  task automatic verifyFrame(input string name, input logic [7:0] resp);
    int nFull;
    logic isOsd;
    nFull = txBytes.size();
    isOsd = (txBytes[0] == TGT_OSD);
    checkOutput({name, ".strobeCount"}, 32'(obsData.size()), 32'(nFull - 1));
    for (int i = 0; i < obsData.size() && i < nFull - 1; i++) begin
      checkOutput($sformatf("%s.data[%0d]", name, i), 32'(obsData[i]), 32'(txBytes[i+1]));
      checkOutput($sformatf("%s.start[%0d]", name, i), 32'(obsStart[i]), 32'(i == 0));
      checkOutput($sformatf("%s.strb[%0d]", name, i), 32'(obsStrb[i]), 32'd1);
      checkOutput($sformatf("%s.osd[%0d]", name, i), 32'(obsOsd[i]), 32'(isOsd));
    end
    checkOutput({name, ".tgt"}, 32'(tgt), 32'(txBytes[0]));
    if (nFull >= 2) checkOutput({name, ".dataHeld"}, 32'(data), 32'(txBytes[nFull-1]));
    checkOutput({name, ".misoCount"}, 32'(obsMiso.size()), 32'(nFull));
    for (int k = 0; k < obsMiso.size() && k < nFull; k++) begin
      checkOutput($sformatf("%s.miso[%0d]", name, k), 32'(obsMiso[k]), (k == 0) ? 32'(ID) : 32'(resp));
    end
    checkOutput({name, ".busyMid"}, 32'(busyMid), 32'd1);
    checkOutput({name, ".busyIdle"}, 32'(busy), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".miso"}, 32'(miso), 32'd0);
    checkOutput({name, ".tgt"}, 32'(tgt), 32'd0);
    checkOutput({name, ".strobe"}, 32'(dataStrobe), 32'd0);
    checkOutput({name, ".start"}, 32'(dataStart), 32'd0);
    checkOutput({name, ".data"}, 32'(data), 32'd0);
    checkOutput({name, ".osd"}, 32'(osdStrobe), 32'd0);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    resetN   = 1'b0;
    csn      = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    respData = 8'h00;
    misoShift = 8'h00;
    #35;
    checkAllZero("reset");
    resetN = 1'b1;
    #200;

    $display("[TB] OSD enable frame");
    respData = 8'h00;
    txBytes = '{TGT_OSD, OSD_CMD_ENABLE, 8'h01};
    applyStimulus(0);
    verifyFrame("osdEnable", respData);

    $display("[TB] OSD tile write");
    respData = 8'h3A;
    txBytes = '{TGT_OSD, OSD_CMD_WRITE, 8'h05};
    for (int i = 0; i < 8; i++) txBytes.push_back(8'hAA + 8'(i));
    applyStimulus(0);
    verifyFrame("osdWrite", respData);

    $display("[TB] Non-OSD target");
    txBytes = '{TGT_HID, 8'h10, 8'h20};
    applyStimulus(0);
    verifyFrame("hid", respData);

    $display("[TB] Partial byte");
    txBytes = '{TGT_OSD, OSD_CMD_WRITE};
    applyStimulus(5);
    verifyFrame("partial", respData);
    txBytes = '{TGT_OSD, OSD_CMD_ENABLE, 8'h00};
    applyStimulus(0);
    verifyFrame("afterPartial", respData);

    $display("[TB] MISO reply");
    respData = 8'hC3;
    txBytes = '{TGT_HID, 8'h00, 8'h00};
    applyStimulus(0);
    verifyFrame("misoReply", respData);

    $display("[TB] Reset mid-frame");
    clearObs();
    csn = 1'b0;
    #200;
    sendByte(TGT_OSD);
    sendByte(OSD_CMD_ENABLE);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    resetN = 1'b0;
    #1;
    checkAllZero("resetMid");
    #100;
    resetN = 1'b1;
    clearObs();
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    sendByte(8'h55);
    sendByte(8'hA5);
    checkOutput("resetMid.busyWait", 32'(busy), 32'd1);
    #60;
    csn = 1'b1;
    #300;
    checkOutput("resetMid.noStrobes", 32'(obsData.size()), 32'd0);
    checkOutput("resetMid.tgt", 32'(tgt), 32'd0);
    txBytes = '{TGT_OSD, OSD_CMD_ENABLE, 8'h01};
    applyStimulus(0);
    verifyFrame("afterReset", respData);

    $display("[TB] Random frames");
    for (int f = 0; f < 20; f++) begin
      int nBytes;
      int extra;
      logic [7:0] target;
      case ($urandom_range(0, 4))
        0, 1:    target = TGT_OSD;
        2:       target = TGT_HID;
        3:       target = TGT_CFG;
        default: target = 8'($urandom_range(0, 255));
      endcase
      nBytes = $urandom_range(1, 7);
      extra  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      respData = 8'($urandom_range(0, 255));
      txBytes = '{target};
      for (int i = 1; i < nBytes; i++) txBytes.push_back(8'($urandom_range(0, 255)));
      applyStimulus(extra);
      verifyFrame($sformatf("rand%0d", f), respData);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
